// File: rtl/lb_regbank.sv
// lb_regbank: local-bus register bank with RW registers, RO status words and 2-cycle read latency.
// Optional error counter at offset 2*NREG enabled by LB_REGBANK_ERRCNT_EN.
module lb_regbank #(
  parameter int LBAWIDTH = 24,
  parameter int LBDWIDTH = 32,
  parameter int LBCWIDTH = 8,
  parameter int NREG = 16,
  parameter logic [LBAWIDTH-1:0] BASEADDR = 24'h000100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LBAWIDTH-1:0]      waddr,
  input  logic [LBDWIDTH-1:0]      wdata,
  input  logic                     wvalid,
  input  logic [LBCWIDTH-1:0]      wctrl,
  input  logic [LBCWIDTH-1:0]      writecmd,
  input  logic                     read,
  input  logic [NREG*LBDWIDTH-1:0] status,
  output logic [NREG*LBDWIDTH-1:0] regs,
  output logic [NREG-1:0]          wstrobe,
  output logic [LBDWIDTH-1:0]      rdata,
  output logic                     rvalid
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [LBAWIDTH-1:0] NRW = LBAWIDTH'(NREG);
  localparam logic [LBAWIDTH-1:0] NALL = LBAWIDTH'(2 * NREG);
  logic [LBDWIDTH-1:0] regs_q [NREG];
  logic [LBDWIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0] wstrobe_q, wstrobe_d;
  logic rd1_q, rd1_d, rvalid_q, rvalid_d;
  logic [LBDWIDTH-1:0] rd1_data_q, rd1_data_d, rdata_q, rdata_d, map_data, sel_data;
  logic [LBAWIDTH-1:0] off;
  logic in_range, hit_rw, hit_ro, wr, wr_rw;
  logic [IW-1:0] rw_idx, ro_idx;
  always_comb begin
    off = waddr - BASEADDR;
    in_range = waddr >= BASEADDR;
    hit_rw = in_range && off < NRW;
    hit_ro = in_range && off >= NRW && off < NALL;
    rw_idx = IW'(off);
    ro_idx = IW'(off - NRW);
    wr = wvalid && wctrl == writecmd;
    wr_rw = wr && hit_rw;
    map_data = hit_rw ? regs_q[rw_idx] :
               hit_ro ? status[ro_idx*LBDWIDTH +: LBDWIDTH] : LBDWIDTH'(32'hDEADBEEF);
    for (int k = 0; k < NREG; k++) begin
      wstrobe_d[k] = wr_rw && rw_idx == IW'(k);
      regs_d[k] = wstrobe_d[k] ? wdata : regs_q[k];
    end
    // read data is captured from pre-write state so a same-cycle write is not visible
    rd1_d = read;
    rd1_data_d = read ? sel_data : rd1_data_q;
    rvalid_d = rd1_q;
    rdata_d = rd1_q ? rd1_data_q : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      wstrobe_q <= '0;
      rd1_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      regs_q <= regs_d;
      wstrobe_q <= wstrobe_d;
      rd1_q <= rd1_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
    rd1_data_q <= rd1_data_d;
  end
`ifdef LB_REGBANK_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic [16:0] err_sum;
  logic hit_err, rd_err, wr_err;
  always_comb begin
    hit_err = in_range && off == NALL;
    rd_err = read && !(hit_rw || hit_ro || hit_err);
    wr_err = wr && !(hit_rw || hit_err);
    err_sum = {1'b0, err_q} + 17'(rd_err) + 17'(wr_err);
    err_d = (wr && hit_err) ? '0 : err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
  always_ff @(posedge clk) err_q <= reset ? '0 : err_d;
  assign sel_data = hit_err ? LBDWIDTH'(err_q) : map_data;
`else
  assign sel_data = map_data;
`endif
  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs[g*LBDWIDTH +: LBDWIDTH] = regs_q[g];
  end
  assign wstrobe = wstrobe_q;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: tb/tb_lb_regbank.sv
// tb_lb_regbank: directed vector table, corner sequences and random traffic against a reference model.
module tb_lb_regbank;
  localparam logic [23:0] BASE = 24'h000100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic wvalid = 1'b0;
  logic [7:0] wctrl = 8'h01;
  logic [7:0] writecmd = 8'h01;
  logic read = 1'b0;
  logic [511:0] status, regs;
  logic [15:0] wstrobe;
  logic [31:0] rdata;
  logic rvalid;
  int nchk = 0, nerr = 0, ecyc = 0;

  lb_regbank dut (.clk(clk), .reset(reset), .waddr(waddr), .wdata(wdata), .wvalid(wvalid),
    .wctrl(wctrl), .writecmd(writecmd), .read(read), .status(status), .regs(regs),
    .wstrobe(wstrobe), .rdata(rdata), .rvalid(rvalid));

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } pend_t;
  pend_t pend[$];
  logic [31:0] m_regs [16];
  logic [15:0] m_strobe = '0;
  logic [31:0] m_rdata = '0;
  logic m_rvalid = 1'b0;
  int m_err = 0;

  // 0 = RW, 1 = RO, 2 = error counter, 3 = unmapped
  function automatic int cls(logic [23:0] a);
    int off;
    if (a < BASE) return 3;
    off = int'(a - BASE);
    if (off < 16) return 0;
    if (off < 32) return 1;
`ifdef LB_REGBANK_ERRCNT_EN
    if (off == 32) return 2;
`endif
    return 3;
  endfunction

  function automatic logic [31:0] lookup(logic [23:0] a);
    int off = int'(a - BASE);
    case (cls(a))
      0: return m_regs[off];
      1: return status[(off-16)*32 +: 32];
      2: return {16'h0, 16'(m_err)};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [511:0] flat;
    int c;
    @(posedge clk);
    #1;
    ecyc++;
    m_rvalid = 1'b0;
    m_strobe = '0;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      pend.delete();
      m_rdata = '0;
      m_err = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == ecyc) begin
        m_rvalid = 1'b1;
        m_rdata = pend.pop_front().data;
      end
      c = cls(waddr);
      if (read) pend.push_back('{ecyc + 1, lookup(waddr)});
      if (wvalid && wctrl == writecmd && c == 0) begin
        m_regs[int'(waddr - BASE)] = wdata;
        m_strobe[int'(waddr - BASE)] = 1'b1;
      end
      if (wvalid && wctrl == writecmd && c == 2) m_err = 0;
      else begin
        m_err += int'(read && c == 3) + int'(wvalid && wctrl == writecmd && (c == 1 || c == 3));
        if (m_err > 65535) m_err = 65535;
      end
    end
    for (int i = 0; i < 16; i++) flat[i*32 +: 32] = m_regs[i];
    chk("rvalid", 512'(rvalid), 512'(m_rvalid));
    chk("rdata", 512'(rdata), 512'(m_rdata));
    chk("wstrobe", 512'(wstrobe), 512'(m_strobe));
    chk("regs", regs, flat);
  endtask

  task automatic idle();
    read = 1'b0;
    wvalid = 1'b0;
    wctrl = 8'h01;
  endtask

  task automatic do_write(logic [23:0] a, logic [31:0] d);
    waddr = a; wdata = d; wvalid = 1'b1; wctrl = 8'h01;
    tick();
    idle();
  endtask

  task automatic rd_check(string name, logic [23:0] a, logic [31:0] exp);
    waddr = a; read = 1'b1;
    tick();
    idle();
    tick();
    chk({name, "_rvalid"}, 512'(rvalid), 512'(1'b1));
    chk({name, "_rdata"}, 512'(rdata), 512'(exp));
  endtask

  typedef struct {
    logic wr; logic rd; logic [23:0] addr; logic [7:0] ctrl;
    logic [31:0] data; logic [15:0] strobe; logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  initial begin
    for (int k = 0; k < 16; k++) status[k*32 +: 32] = 32'h5A000000 | k;
    status[2*32 +: 32] = 32'h12345678;
    vecs[0]  = '{1, 0, 24'h000103, 8'h01, 32'hCAFE0001, 16'h0008, 32'h0};
    vecs[1]  = '{0, 1, 24'h000103, 8'h01, 32'h0,        16'h0000, 32'hCAFE0001};
    vecs[2]  = '{0, 1, 24'h000112, 8'h01, 32'h0,        16'h0000, 32'h12345678};
    vecs[3]  = '{1, 0, 24'h000112, 8'h01, 32'h0,        16'h0000, 32'h0};
    vecs[4]  = '{0, 1, 24'h000112, 8'h01, 32'h0,        16'h0000, 32'h12345678};
    vecs[5]  = '{0, 1, 24'h000000, 8'h01, 32'h0,        16'h0000, 32'hDEADBEEF};
    vecs[6]  = '{1, 0, 24'h000100, 8'h02, 32'h11111111, 16'h0000, 32'h0};
    vecs[7]  = '{0, 1, 24'h000100, 8'h01, 32'h0,        16'h0000, 32'h0};
    vecs[8]  = '{0, 1, 24'h0000FF, 8'h01, 32'h0,        16'h0000, 32'hDEADBEEF};
    vecs[9]  = '{1, 0, 24'h00010F, 8'h01, 32'hA5A5A5A5, 16'h8000, 32'h0};
    vecs[10] = '{0, 1, 24'h00010F, 8'h01, 32'h0,        16'h0000, 32'hA5A5A5A5};
    vecs[11] = '{0, 1, 24'h00011F, 8'h01, 32'h0,        16'h0000, 32'h5A00000F};
    vecs[12] = '{0, 1, 24'h000121, 8'h01, 32'h0,        16'h0000, 32'hDEADBEEF};
    tick();
    tick();
    reset = 1'b0;
    foreach (vecs[i]) begin
      waddr = vecs[i].addr; wdata = vecs[i].data; wvalid = vecs[i].wr;
      wctrl = vecs[i].ctrl; read = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d_wstrobe", i), 512'(wstrobe), 512'(vecs[i].strobe));
      idle();
      tick();
      if (vecs[i].rd) begin
        chk($sformatf("vec%0d_rvalid", i), 512'(rvalid), 512'(1'b1));
        chk($sformatf("vec%0d_rdata", i), 512'(rdata), 512'(vecs[i].exp));
      end
      tick();
      chk($sformatf("vec%0d_strobe_off", i), 512'(wstrobe), 512'(0));
    end
    // back-to-back reads, then same-cycle write/read
    do_write(24'h000100, 32'h1);
    do_write(24'h000101, 32'h2);
    do_write(24'h000102, 32'h3);
    read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waddr = BASE + 24'(i);
      if (i > 2) read = 1'b0;
      tick();
      chk($sformatf("burst%0d_rvalid", i), 512'(rvalid), 512'(i >= 1 && i <= 3));
      if (i >= 1 && i <= 3) chk($sformatf("burst%0d_rdata", i), 512'(rdata), 512'(i));
    end
    waddr = 24'h000101; wdata = 32'h99; wvalid = 1'b1; read = 1'b1;
    tick();
    idle();
    tick();
    chk("rw_same_cycle", 512'(rdata), 512'(32'h2));
    chk("rw_same_cycle_new", regs[63:32], 512'(32'h99));
    // read in flight dropped by reset
    waddr = 24'h000103; read = 1'b1;
    tick();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drop_rvalid", 512'(rvalid), 512'(0));
    end
    chk("regs_after_reset", regs, 512'(0));
`ifdef LB_REGBANK_ERRCNT_EN
    waddr = 24'h000000; read = 1'b1;
    tick();
    idle();
    do_write(24'h0001F0, 32'h5);
    do_write(24'h000110, 32'h5);
    tick();
    rd_check("errcnt3", 24'h000120, 32'h3);
    do_write(24'h000120, 32'h0);
    rd_check("errcnt0", 24'h000120, 32'h0);
`else
    rd_check("off2n_unmapped", 24'h000120, 32'hDEADBEEF);
`endif
    for (int i = 0; i < 600; i++) begin
      waddr = ($urandom_range(0, 7) == 0) ? 24'($urandom) : BASE - 24'd2 + 24'($urandom_range(0, 36));
      wdata = $urandom;
      wvalid = $urandom_range(0, 1) == 1;
      wctrl = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h01;
      read = $urandom_range(0, 1) == 1;
      reset = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 15) == 0) status[$urandom_range(0, 15)*32 +: 32] = $urandom;
      tick();
    end
    idle();
    reset = 1'b0;
    tick();
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
